inst_cache_dm: RTL and testbench
================================

// Module: inst_cache_dm
// PURPOSE
//  Parametrised direct-mapped instruction cache between the fetch stage and
//  instruction memory. Hits return in one cycle; misses refill a whole line
//  from a word-wide memory read port with a req/ack handshake. Memory words
//  are byte-reversed on refill, so fetch always sees decode byte order.
//  Supports a whole-cache flush (invalidate all lines).
// PARAMETERS
//  ADDR_W     32  byte-address width of addr and mem_addr
//  LINE_NUM   16  number of cache lines (power of 2, >=2)
//  LINE_WORDS 4   32-bit words per line (power of 2, >=2)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  ce         in   1       fetch request valid
//  addr       in   ADDR_W  fetch byte address; addr[1:0] ignored
//  flush      in   1       invalidate all lines
//  ready      out  1       cache can accept a request this cycle
//  inst       out  32      instruction, decode byte order
//  inst_valid out  1       one-cycle pulse: inst holds requested word
//  mem_req    out  1       memory read request
//  mem_addr   out  ADDR_W  word-aligned memory read address
//  mem_rdata  in   32      memory read data, memory byte order
//  mem_ack    in   1       mem_rdata valid; completes current beat
// BEHAVIOUR
//  Address split: OFF=log2(LINE_WORDS), IDX=log2(LINE_NUM);
//   word=addr[2+:OFF], index=addr[2+OFF+:IDX], tag=addr[ADDR_W-1:2+OFF+IDX].
//  Storage: valid[LINE_NUM], tag[LINE_NUM], data[LINE_NUM*LINE_WORDS]x32.
//  Reset: state=IDLE, all valid=0, ready=1, inst=0, inst_valid=0,
//   mem_req=0, mem_addr=0. Reset mid-refill abandons the refill (no
//   inst_valid), leaves the line invalid; a late mem_ack is ignored.
//  States: IDLE, REFILL, RESP.
//  IDLE: ready=1. Request accepted when ce=1 (latch addr).
//   Hit (valid & tag match): next cycle inst=data, inst_valid=1; stay IDLE.
//   Back-to-back hits sustain one instruction per cycle.
//   Miss: -> REFILL, beat=0, valid[index] cleared at acceptance.
//  REFILL: ready=0, mem_req=1, mem_addr={tag,index,beat,2'b00}.
//   On mem_ack: data[index][beat]={rdata[7:0],rdata[15:8],rdata[23:16],
//   rdata[31:24]}; beat++. mem_req stays high across beats; no gap needed.
//   On ack of beat LINE_WORDS-1: write tag, set valid (unless flush was seen
//   during this refill), mem_req=0 next cycle, -> RESP.
//  RESP: ready=0; inst=requested word (bypassed if it was the last beat),
//   inst_valid=1 for exactly one cycle; -> IDLE.
//  ce while ready=0 is ignored; requester holds ce/addr until inst_valid.
//  inst holds its last value between pulses.
//  flush: clears all valid bits next cycle, any state. flush & ce same cycle
//   in IDLE: flush wins, request treated as a miss. Flush during REFILL:
//   refill completes, instruction delivered, line stays invalid.
//  mem_ack while mem_req=0 is ignored.
// TESTING
//  1 Reset, ce=1 addr=0x40, LINE_WORDS=4, mem returns 0x78563412..:
//    mem_addr 0x40,44,48,4C; inst=0x12345678, inst_valid one pulse.
//  2 After (1): ce addr=0x44,0x48 back-to-back -> inst_valid each cycle
//    at latency 1, no mem_req.
//  3 Conflict: fetch 0x40 then 0x440 (same index, LINE_NUM=16) -> refill;
//    refetch 0x40 -> miss again.
//  4 mem_ack stalls 3 cycles per beat -> mem_req/mem_addr stable until ack;
//    correct word delivered.
//  5 flush pulse mid-refill -> instruction delivered; next same-line fetch
//    misses. flush in IDLE -> all lines miss.
//  6 rst during beat 2 of a refill -> no inst_valid, ready=1 next cycle,
//    mem_req=0; refetch same address does a full 4-beat refill.

Source files
------------

// File: rtl/inst_cache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : inst_cache_dm
//  Purpose  : Direct-mapped instruction cache. One-cycle hits, whole-line
//             refill over a word-wide req/ack read port, byte reversal of
//             memory words on refill, whole-cache flush.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_cache_dm #(
  parameter int ADDR_W     = 32,
  parameter int LINE_NUM   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic              ready,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Line bookkeeping and storage
  logic [LINE_NUM-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  logic [31:0]         data_q [LINE_NUM*LINE_WORDS];

  // Captured request and refill progress
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic [OFF_W-1:0] req_word_q;
  logic [OFF_W-1:0] beat_q;
  logic             flush_seen_q;
  logic [31:0]      inst_q;
  logic             inst_valid_q;

  // Address fields of the incoming fetch
  logic [OFF_W-1:0] w_word;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_accept;
  logic             w_beat_done;
  logic             w_last_beat;
  logic [31:0]      w_swapped;
  logic             unused_addr_lsb;

  assign w_word = addr[2 +: OFF_W];
  assign w_idx  = addr[2+OFF_W +: IDX_W];
  assign w_tag  = addr[ADDR_W-1 -: TAG_W];

  // Byte offset within a word is meaningless for 32-bit instruction fetch
  assign unused_addr_lsb = ^addr[1:0];

  // Memory words arrive in memory byte order; fetch wants them reversed
  assign w_swapped = {mem_rdata[7:0], mem_rdata[15:8],
                      mem_rdata[23:16], mem_rdata[31:24]};

  // A simultaneous flush wins over the lookup, so the request becomes a miss
  assign w_hit       = valid_q[w_idx] && (tag_q[w_idx] == w_tag) && !flush;
  assign w_accept    = (state_q == ST_IDLE) && ce;
  assign w_beat_done = (state_q == ST_REFILL) && mem_ack;
  assign w_last_beat = w_beat_done && (beat_q == LAST_BEAT);

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

  // Next-state and handshake outputs, derived from the current state
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (w_accept && !w_hit) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, req_idx_q, beat_q, 2'b00};
        if (w_last_beat) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture, refill progress, response and valid-bit maintenance
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_word_q   <= '0;
      beat_q       <= '0;
      flush_seen_q <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              inst_q       <= data_q[{w_idx, w_word}];
              inst_valid_q <= 1'b1;
            end else begin
              req_tag_q      <= w_tag;
              req_idx_q      <= w_idx;
              req_word_q     <= w_word;
              beat_q         <= '0;
              flush_seen_q   <= 1'b0;
              valid_q[w_idx] <= 1'b0;
            end
          end
        end
        ST_REFILL: begin
          if (flush) begin
            flush_seen_q <= 1'b1;
          end
          if (w_beat_done) begin
            beat_q <= beat_q + OFF_W'(1);
          end
          if (w_last_beat) begin
            if (!flush_seen_q) begin
              valid_q[req_idx_q] <= 1'b1;
            end
            // The requested word may be the one arriving right now
            if (req_word_q == LAST_BEAT) begin
              inst_q <= w_swapped;
            end else begin
              inst_q <= data_q[{req_idx_q, req_word_q}];
            end
            inst_valid_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      // Flush overrides any valid bit set in the same cycle
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  // Line data and tag storage, written only during refill
  always_ff @(posedge clk) begin
    if (w_beat_done && !rst) begin
      data_q[{req_idx_q, beat_q}] <= w_swapped;
    end
    if (w_last_beat && !rst) begin
      tag_q[req_idx_q] <= req_tag_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_cache_dm
//  Purpose  : Self-checking bench for inst_cache_dm with a line-level
//             reference model and a stalling memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_cache_dm;

  localparam int LN = 16;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        flush;
  logic        ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which line holds which tag
  bit m_valid [LN];
  int m_tag   [LN];

  // Memory responder configuration and log of acked beat addresses
  int          stall_cfg   = 0;
  bit          spurious_en = 1'b0;
  logic [31:0] beats [$];
  bit          pending = 1'b0;
  int          stall_left = 0;
  logic [31:0] hold_addr = '0;

  inst_cache_dm #(.ADDR_W(32), .LINE_NUM(LN), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .flush(flush),
    .ready(ready), .inst(inst), .inst_valid(inst_valid),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'h7856_3412;
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / (4 * LW)) % LN);
  endfunction

  function automatic int line_tag(input logic [31:0] a);
    return int'(a / (4 * LW * LN));
  endfunction

  // Memory side: answer each beat after a stall, record it, watch stability
  always @(negedge clk) begin
    if (mem_req) begin
      if (pending) begin
        n_cmp++;
        if (mem_addr !== hold_addr) begin
          n_bad++;
          $display("FAIL mem_addr_stable: got %h expected %h", mem_addr, hold_addr);
        end
      end else begin
        pending    = 1'b1;
        hold_addr  = mem_addr;
        stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
      end
      if (stall_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = memf(mem_addr);
        beats.push_back(mem_addr);
        pending   = 1'b0;
      end else begin
        stall_left--;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      pending   = 1'b0;
      mem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < LN; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch, held until inst_valid; optional flush pulse after flush_at beats
  task automatic do_fetch(input logic [31:0] a, input int flush_at, output bit missed);
    logic [31:0] exp;
    bit exp_hit;
    int idx, cyc;
    bit got, flushed;
    idx     = line_idx(a);
    exp_hit = m_valid[idx] && (m_tag[idx] == line_tag(a));
    exp     = bswap(memf({a[31:2], 2'b00}));
    beats.delete();
    ce = 1'b1; addr = a;
    cyc = 0; got = 1'b0; flushed = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (inst_valid) got = 1'b1;
      else if (flush_at >= 0 && !flushed && mem_req && beats.size() >= flush_at) begin
        flush = 1'b1; flushed = 1'b1;
      end
    end
    ce = 1'b0; flush = 1'b0;
    missed = (beats.size() != 0);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL fetch_timeout addr %h: no inst_valid in %0d cycles", a, cyc);
    end
    n_cmp++;
    if (inst !== exp) begin
      n_bad++;
      $display("FAIL fetch_data addr %h: got %h expected %h", a, inst, exp);
    end
    if (exp_hit) begin
      n_cmp++;
      if (cyc != 1 || beats.size() != 0) begin
        n_bad++;
        $display("FAIL hit_latency addr %h: got %0d cycles %0d beats expected 1 cycle 0 beats",
                 a, cyc, beats.size());
      end
    end else begin
      n_cmp++;
      if (beats.size() != LW) begin
        n_bad++;
        $display("FAIL refill_beats addr %h: got %0d expected %0d", a, beats.size(), LW);
      end else begin
        for (int i = 0; i < LW; i++) begin
          logic [31:0] ea;
          ea = (a & ~32'(4 * LW - 1)) + 32'(4 * i);
          n_cmp++;
          if (beats[i] !== ea) begin
            n_bad++;
            $display("FAIL refill_addr beat %0d: got %h expected %h", i, beats[i], ea);
          end
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0 || inst !== exp) begin
      n_bad++;
      $display("FAIL pulse_hold addr %h: got valid %b inst %h expected valid 0 inst %h",
               a, inst_valid, inst, exp);
    end
    if (!exp_hit) begin
      m_tag[idx]   = line_tag(a);
      m_valid[idx] = 1'b1;
    end
    if (flushed) clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; addr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || inst !== 32'h0 || inst_valid !== 1'b0 ||
        mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: got ready %b inst %h iv %b req %b maddr %h expected 1 0 0 0 0",
               ready, inst, inst_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_first_refill();
    bit m;
    stall_cfg = 0;
    do_fetch(32'h40, -1, m);
    n_cmp++;
    if (inst !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL first_word: got %h expected 12345678", inst);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4];
    seq[0] = 32'h44; seq[1] = 32'h48; seq[2] = 32'h4C; seq[3] = 32'h40;
    ce = 1'b1; addr = seq[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) addr = seq[i+1];
      else ce = 1'b0;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== bswap(memf(seq[i])) || mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL back_to_back %h: got iv %b inst %h req %b expected 1 %h 0",
                 seq[i], inst_valid, inst, mem_req, bswap(memf(seq[i])));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    bit m;
    do_fetch(32'h440, -1, m);
    do_fetch(32'h40, -1, m);
    n_cmp++;
    if (m !== 1'b1) begin
      n_bad++;
      $display("FAIL conflict_refetch: got miss %b expected 1", m);
    end
  endtask

  task automatic test_stall();
    bit m;
    stall_cfg = 3;
    do_fetch(32'h208, -1, m);
    do_fetch(32'h20C, -1, m);
    stall_cfg = 0;
  endtask

  task automatic test_flush();
    bit m;
    stall_cfg = 1;
    do_fetch(32'h304, 1, m);
    do_fetch(32'h304, -1, m);
    n_cmp++;
    if (m !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_refill_line: got miss %b expected 1", m);
    end
    stall_cfg = 0;
    do_fetch(32'h80, -1, m);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_model();
    do_fetch(32'h304, -1, m);
    n_cmp++;
    if (m !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_idle_a: got miss %b expected 1", m);
    end
    do_fetch(32'h80, -1, m);
    n_cmp++;
    if (m !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_idle_b: got miss %b expected 1", m);
    end
  endtask

  task automatic test_reset_mid_refill();
    bit m, seen_iv;
    int cyc;
    stall_cfg = 3; spurious_en = 1'b1;
    beats.delete();
    ce = 1'b1; addr = 32'h5A8;
    cyc = 0;
    while (!(beats.size() >= 2 && mem_req) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    n_cmp++;
    if (cyc >= 100) begin
      n_bad++;
      $display("FAIL rst_mid_reach: got %0d beats expected 2", beats.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ce = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_state: got ready %b req %b iv %b expected 1 0 0",
               ready, mem_req, inst_valid);
    end
    seen_iv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (inst_valid || mem_req) seen_iv = 1'b1;
    end
    n_cmp++;
    if (seen_iv) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: got activity 1 expected 0");
    end
    clear_model();
    stall_cfg = 0;
    do_fetch(32'h5A8, -1, m);
    n_cmp++;
    if (m !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_refetch: got miss %b expected 1", m);
    end
    spurious_en = 1'b0;
  endtask

  task automatic test_random();
    bit m;
    stall_cfg = -1; spurious_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      int r;
      a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom)};
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
      end
      do_fetch(a, (r == 1) ? 1 : -1, m);
    end
    stall_cfg = 0; spurious_en = 1'b0;
  endtask

  initial begin
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_first_refill();
    test_back_to_back();
    test_conflict();
    test_stall();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
